scpu_sequencer: RTL and testbench

//  Program loader and run controller for the 5-stage SCPU pipeline. Accepts a program over a

---
 rtl/scpu_pkg.sv | 20 ++
 rtl/scpu_issue_tracker.sv | 33 +++
 rtl/scpu_sequencer.sv | 140 ++++++++++++++
 tb/tb_scpu_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpu_pkg.sv
// Shared widths, opcode field position and sequencer state encoding for the SCPU
// program loader / run controller.
package scpu_pkg;
  localparam int ADDR_W   = 8;
  localparam int INS_W    = 16;
  localparam int DATA_W   = 8;
  localparam int PIPE_LAT = 4;
  localparam int DEPTH    = 2 ** ADDR_W;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam logic [OPC_HI-OPC_LO:0] HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/scpu_issue_tracker.sv
// Tracks which issued instruction index is in each SCPU pipeline stage so the
// result leaving WB can be tagged with its valid strobe and index.
module scpu_issue_tracker
  import scpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_vld_i,
  input  logic [ADDR_W-1:0] push_tag_i,
  output logic              tail_vld_o,
  output logic [ADDR_W-1:0] tail_tag_o,
  output logic              inflight_o
);
  logic [PIPE_LAT-1:0] vld_q;
  logic [ADDR_W-1:0]   tag_q [PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q    <= flush_i ? '0 : {vld_q[PIPE_LAT-2:0], push_vld_i};
      tag_q[0] <= push_tag_i;
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail_vld_o = vld_q[PIPE_LAT-1];
  assign tail_tag_o = tag_q[PIPE_LAT-1];
  // Entries that will still be in flight after the next shift.
  assign inflight_o = |vld_q[PIPE_LAT-2:0];
endmodule

// File: rtl/scpu_sequencer.sv
// Loads a program into SCPU instruction memory over a valid/ready stream, then
// issues it one index per cycle, drains the pipeline and tags results leaving WB.
module scpu_sequencer
  import scpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [INS_W-1:0]  ld_data,
  input  logic              ld_last,
  input  logic              start,
  output logic [ADDR_W-1:0] ins_index,
  output logic              ins_we,
  output logic [INS_W-1:0]  instructs,
  input  logic [INS_W-1:0]  peek_ins,
  input  logic [DATA_W-1:0] res,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_tag,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_LEN  = (ADDR_W+1)'(1);

  state_e           state_q, state_d;
  logic [ADDR_W:0]  pc_q, pc_d;
  logic [ADDR_W:0]  len_q, len_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic             ins_we_q, ins_we_d;
  logic             loaded_q, loaded_d;
  logic             done_q, done_d;
  logic             accept, halt, push_vld, flush, inflight;
  logic             unused_ok;

  assign ld_ready = (state_q == IDLE) || ((state_q == LOAD) && (len_q != FULL_LEN));
  assign accept   = ld_valid && ld_ready;
  // pc is one bit wider than the index so a full 2**ADDR_W program stops instead of wrapping.
  assign halt     = (peek_ins[OPC_HI:OPC_LO] == HALT_OP) || (pc_q == len_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    ins_d    = ins_q;
    ins_we_d = 1'b0;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    push_vld = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ins_we_d = 1'b1;
          ins_d    = ld_data;
          pc_d     = '0;
          len_d    = ONE_LEN;
          loaded_d = ld_last;
          state_d  = ld_last ? IDLE : LOAD;
        end else if (start && loaded_q) begin
          pc_d    = '0;
          flush   = 1'b1;
          state_d = RUN;
        end
      end
      LOAD: begin
        if (accept) begin
          ins_we_d = 1'b1;
          ins_d    = ld_data;
          pc_d     = len_q;
          len_d    = len_q + 1'b1;
          if (ld_last) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end
        end else if (len_q == FULL_LEN) begin
          loaded_d = 1'b1;
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DRAIN;
        end else begin
          push_vld = 1'b1;
          pc_d     = pc_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!inflight) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      ins_q    <= '0;
      ins_we_q <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      ins_q    <= ins_d;
      ins_we_q <= ins_we_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
    end
  end

  scpu_issue_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_vld_i (push_vld),
    .push_tag_i (pc_q[ADDR_W-1:0]),
    .tail_vld_o (res_valid),
    .tail_tag_o (res_tag),
    .inflight_o (inflight)
  );

  assign ins_index = pc_q[ADDR_W-1:0];
  assign ins_we    = ins_we_q;
  assign instructs = ins_q;
  assign prog_len  = len_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // The result data itself travels alongside in the wrapper; only its timing matters here.
  assign unused_ok = ^{res, peek_ins[OPC_LO-1:0]};
endmodule

// File: tb/tb_scpu_sequencer.sv
// Directed bench for scpu_sequencer with a behavioural instruction memory.
module tb_scpu_sequencer;
  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        start;
  logic [7:0]  ins_index;
  logic        ins_we;
  logic [15:0] instructs;
  logic [15:0] peek_ins;
  logic [7:0]  res;
  logic        res_valid;
  logic [7:0]  res_tag;
  logic [8:0]  prog_len;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];
  logic [15:0] prog_words [8];

  scpu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .start     (start),
    .ins_index (ins_index),
    .ins_we    (ins_we),
    .instructs (instructs),
    .peek_ins  (peek_ins),
    .res       (res),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .prog_len  (prog_len),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (ins_we) mem[ins_index] <= instructs;
  assign peek_ins = mem[ins_index];
  assign res      = ins_index ^ 8'h5A;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog_words[i];
      ld_last  = (i == n - 1);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0;
    step(); step();
    checks++; if (ins_index !== 8'd0) begin errors++; $display("FAIL reset_ins_index got=%0d exp=0", ins_index); end
    checks++; if (ins_we !== 1'b0) begin errors++; $display("FAIL reset_ins_we got=%0b exp=0", ins_we); end
    checks++; if (instructs !== 16'd0) begin errors++; $display("FAIL reset_instructs got=%h exp=0", instructs); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    checks++; if (res_tag !== 8'd0) begin errors++; $display("FAIL reset_res_tag got=%0d exp=0", res_tag); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); end
    rst_n = 1'b1;
    step();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%0b exp=1", ld_ready); end
  endtask

  task automatic test_start_unloaded();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unloaded_busy got=%0b exp=0", busy); end
    checks++; if (ins_index !== 8'd0) begin errors++; $display("FAIL unloaded_ins_index got=%0d exp=0", ins_index); end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL unloaded_idle c=%0d busy=%0b res_valid=%0b done=%0b exp=000", c, busy, res_valid, done);
      end
    end
  endtask

  task automatic test_load();
    logic [15:0] w [3];
    w[0] = 16'h1A01; w[1] = 16'h2B02; w[2] = 16'h3C03;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = w[i]; ld_last = (i == 2);
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready i=%0d got=%0b exp=1", i, ld_ready); end
      step();
      checks++;
      if (ins_we !== 1'b1 || ins_index !== 8'(i) || instructs !== w[i] || prog_len !== 9'(i + 1)) begin
        errors++; $display("FAIL load_write i=%0d got we=%0b idx=%0d ins=%h len=%0d exp we=1 idx=%0d ins=%h len=%0d",
                           i, ins_we, ins_index, instructs, prog_len, i, w[i], i + 1);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++; if (busy !== 1'b0 || ld_ready !== 1'b1) begin errors++; $display("FAIL load_end got busy=%0b ready=%0b exp busy=0 ready=1", busy, ld_ready); end
    step();
    checks++; if (ins_we !== 1'b0 || prog_len !== 9'd3) begin errors++; $display("FAIL load_idle got we=%0b len=%0d exp we=0 len=3", ins_we, prog_len); end
  endtask

  task automatic test_run_add();
    int vcnt;
    prog_words[0] = 16'h1012; prog_words[1] = 16'h1123; prog_words[2] = 16'h1234;
    load_prog(3);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || ins_index !== 8'd0) begin errors++; $display("FAIL add_start got busy=%0b idx=%0d exp busy=1 idx=0", busy, ins_index); end
    vcnt = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++;
      if (ins_index !== 8'((c < 3) ? c : 3) || ins_we !== 1'b0) begin
        errors++; $display("FAIL add_pc c=%0d got idx=%0d we=%0b exp idx=%0d we=0", c, ins_index, ins_we, (c < 3) ? c : 3);
      end
      checks++;
      if (res_valid !== (c >= 4 && c <= 6)) begin
        errors++; $display("FAIL add_res_valid c=%0d got=%0b exp=%0b", c, res_valid, (c >= 4 && c <= 6));
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (res_tag !== 8'(c - 4)) begin errors++; $display("FAIL add_res_tag c=%0d got=%0d exp=%0d", c, res_tag, c - 4); end
        vcnt++;
      end
      checks++;
      if (done !== (c == 7) || busy !== (c < 7)) begin
        errors++; $display("FAIL add_done c=%0d got done=%0b busy=%0b exp done=%0b busy=%0b", c, done, busy, c == 7, c < 7);
      end
    end
    checks++; if (vcnt != 3) begin errors++; $display("FAIL add_res_count got=%0d exp=3", vcnt); end
  endtask

  task automatic test_halt();
    int vcnt;
    prog_words[0] = 16'h1001; prog_words[1] = 16'h2002; prog_words[2] = 16'hF000; prog_words[3] = 16'h3003;
    load_prog(4);
    checks++; if (prog_len !== 9'd4) begin errors++; $display("FAIL halt_len got=%0d exp=4", prog_len); end
    start = 1'b1;
    step();
    start = 1'b0;
    vcnt = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (ins_index !== 8'((c < 2) ? c : 2)) begin
        errors++; $display("FAIL halt_pc c=%0d got=%0d exp=%0d", c, ins_index, (c < 2) ? c : 2);
      end
      checks++;
      if (res_valid !== (c == 4 || c == 5)) begin
        errors++; $display("FAIL halt_res_valid c=%0d got=%0b exp=%0b", c, res_valid, (c == 4 || c == 5));
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (res_tag !== 8'(c - 4)) begin errors++; $display("FAIL halt_res_tag c=%0d got=%0d exp=%0d", c, res_tag, c - 4); end
        vcnt++;
      end
      checks++;
      if (done !== (c == 6)) begin errors++; $display("FAIL halt_done c=%0d got=%0b exp=%0b", c, done, c == 6); end
    end
    checks++; if (vcnt != 2) begin errors++; $display("FAIL halt_res_count got=%0d exp=2", vcnt); end
  endtask

  task automatic test_full_load();
    int vcnt, tag_bad, done_c;
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 16'h1000 + 16'(i); ld_last = 1'b0;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready i=%0d got=%0b exp=1", i, ld_ready); end
      step();
    end
    ld_valid = 1'b0;
    checks++; if (prog_len !== 9'd256) begin errors++; $display("FAIL full_len got=%0d exp=256", prog_len); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop got=%0b exp=0", ld_ready); end
    checks++; if (ins_index !== 8'd255 || instructs !== 16'h10FF) begin errors++; $display("FAIL full_last_write got idx=%0d ins=%h exp idx=255 ins=10ff", ins_index, instructs); end
    step();
    checks++; if (busy !== 1'b0 || prog_len !== 9'd256) begin errors++; $display("FAIL full_idle got busy=%0b len=%0d exp busy=0 len=256", busy, prog_len); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_loaded_start got busy=%0b exp=1", busy); end
    vcnt = 0; tag_bad = 0; done_c = -1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (res_valid === 1'b1) begin
        if (res_tag !== 8'(vcnt)) tag_bad++;
        vcnt++;
      end
      if (done === 1'b1) begin done_c = c; break; end
    end
    checks++; if (done_c != 260) begin errors++; $display("FAIL full_done_cycle got=%0d exp=260", done_c); end
    checks++; if (vcnt != 256) begin errors++; $display("FAIL full_res_count got=%0d exp=256", vcnt); end
    checks++; if (tag_bad != 0) begin errors++; $display("FAIL full_res_tags got=%0d bad exp=0", tag_bad); end
  endtask

  task automatic test_reset_mid_run();
    int vseen, done_c;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%0b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ins_index !== 8'd0 || res_valid !== 1'b0 || prog_len !== 9'd0 || done !== 1'b0 || ins_we !== 1'b0) begin
      errors++; $display("FAIL midrun_async_reset got busy=%0b idx=%0d rv=%0b len=%0d done=%0b we=%0b exp all 0",
                         busy, ins_index, res_valid, prog_len, done, ins_we);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (ld_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrun_release got ready=%0b busy=%0b exp ready=1 busy=0", ld_ready, busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || ins_index !== 8'd0) begin errors++; $display("FAIL midrun_start_ignored got busy=%0b idx=%0d exp busy=0 idx=0", busy, ins_index); end
    vseen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (res_valid === 1'b1 || done === 1'b1) vseen++;
    end
    checks++; if (vseen != 0) begin errors++; $display("FAIL midrun_quiet got=%0d active cycles exp=0", vseen); end
    prog_words[0] = 16'h4044;
    load_prog(1);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_start got busy=%0b exp=1", busy); end
    done_c = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done === 1'b1) begin done_c = c; break; end
    end
    checks++; if (done_c != 5) begin errors++; $display("FAIL reload_done_cycle got=%0d exp=5", done_c); end
  endtask

  initial begin
    test_reset();
    test_start_unloaded();
    test_load();
    test_run_add();
    test_halt();
    test_full_load();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
